// File: rtl/stopwatch_display.sv
// Multiplexed 4-digit seven-segment driver for a stopwatch.
// Digits are captured into a snapshot only at frame boundaries so the
// display never tears mid-frame; outputs are registered one cycle after
// the scan index and snapshot.
module stopwatch_display #(
    parameter int REFRESH_DIV = 4,
    parameter int DP_POS      = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic       snap,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic       frame_done
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [PW-1:0]   r_presc;
    logic [1:0]      r_idx;
    logic [3:0][3:0] r_snap;
    logic            r_pend;

    logic            w_tick;
    logic            w_wrap;
    logic            w_load;
    logic [3:0]      w_blank;
    logic [3:0]      w_digit;
    logic            w_cur_blank;
    logic [6:0]      w_seg;
    logic [3:0]      w_an;
    logic            w_dp;

    // Segment patterns {g,f,e,d,c,b,a}, active-low; non-decimal codes go dark.
    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h7F;
        endcase
    endfunction

    assign w_tick = (r_presc == PW'(REFRESH_DIV - 1));
    assign w_wrap = w_tick && (r_idx == 2'd3);
    // A snap in the wrap cycle itself loads directly, without waiting on pending.
    assign w_load = w_wrap && (r_pend || snap);

    // Leading zeros blank from the top down; the units digit always shows.
    always_comb begin
        w_blank    = 4'b0000;
        w_blank[3] = blank_lz && (r_snap[3] == 4'd0);
        w_blank[2] = w_blank[3] && (r_snap[2] == 4'd0);
        w_blank[1] = w_blank[2] && (r_snap[1] == 4'd0);
    end

    assign w_digit     = r_snap[r_idx];
    assign w_cur_blank = w_blank[r_idx];

    // Next-slot output values; at most one anode low by construction.
    always_comb begin
        w_an  = 4'hF;
        w_seg = 7'h7F;
        w_dp  = 1'b1;
        if (!w_cur_blank) begin
            w_an  = ~(4'b0001 << r_idx);
            w_seg = decode(w_digit);
            w_dp  = (r_idx != 2'(DP_POS));
        end
    end

    // Prescaler and scan index: one slot per REFRESH_DIV cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_presc <= '0;
            r_idx   <= 2'd0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick) r_idx <= r_idx + 2'd1;
        end
    end

    // Snapshot capture at frame wrap; pending remembers snaps seen mid-frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_snap <= '0;
            r_pend <= 1'b0;
        end else if (w_load) begin
            r_snap <= {d3, d2, d1, d0};
            r_pend <= 1'b0;
        end else if (snap) begin
            r_pend <= 1'b1;
        end
    end

    // Registered display outputs and frame pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg        <= 7'h7F;
            an         <= 4'hF;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            seg        <= w_seg;
            an         <= w_an;
            dp         <= w_dp;
            frame_done <= w_wrap;
        end
    end

endmodule

// File: doc/stopwatch_display.md
STOPWATCH_DISPLAY -- requirements
Module: stopwatch_display

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 4: clock cycles each digit is displayed (legal range >= 2).
REQ-002 SHALL have parameter DP_POS, default 2: digit index whose decimal point is lit.
REQ-003 SHALL use one clock and an asynchronous, active-low reset; ports follow.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 d0, d1, d2, d3  input  4 each  BCD digits from the stopwatch counter chain (d0 least significant).
REQ-007 snap  input  1  request to capture d0..d3 for display.
REQ-008 blank_lz  input  1  1 = suppress leading zeros.
REQ-009 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-010 an  output  4  digit anodes, active-low; bit i drives digit i.
REQ-011 dp  output  1  decimal point, active-low.
REQ-012 frame_done  output  1  one-cycle pulse at each frame wrap.

Function
REQ-013 SHALL run a prescaler counting 0..REFRESH_DIV-1 that wraps to 0; tick = prescaler at REFRESH_DIV-1.
REQ-014 SHALL hold a 2-bit scan index idx that advances on tick and wraps from 3 to 0; one frame = 4*REFRESH_DIV cycles.
REQ-015 SHALL define frame wrap as tick with idx==3; frame_done SHALL be 1 in the cycle after each frame wrap and 0 otherwise.
REQ-016 SHALL keep four 4-bit snapshot registers; display SHALL use only snapshot values, never d0..d3 directly.
REQ-017 snap=1 on any edge SHALL set a pending flag; snapshot SHALL load from d0..d3 at frame wrap when pending=1 or snap=1; the pending flag SHALL clear on that load.
REQ-018 Snap asserted in the same cycle as frame wrap SHALL load that cycle's d0..d3; repeated snaps within a frame SHALL produce one load using the values present at the wrap.
REQ-019 Decode (seg, hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10; values 10..15 SHALL give 7F (all off).
REQ-020 Leading-zero blanking (blank_lz=1): digit 3 blank if s3==0; digit 2 blank if s3==0 and s2==0; digit 1 blank if s3, s2 and s1 are all 0; digit 0 never blank.
REQ-021 Blanked digit SHALL give an=1111 and seg=7F in its slot; blank_lz=0 disables blanking.
REQ-022 Non-blanked slot SHALL give an with only bit idx low and seg=decode(snapshot[idx]).
REQ-023 dp SHALL be 0 while idx==DP_POS and its digit is not blanked, else 1.
REQ-024 seg, an, dp SHALL be registered with 1-cycle latency from idx and snapshot, and SHALL never show two anodes low at once.

Reset
REQ-025 reset=0 SHALL immediately force prescaler=0, idx=0, snapshot=0, pending=0, an=1111, seg=7F, dp=1 and frame_done=0, including mid-frame.
REQ-026 The first edge after reset release SHALL drive an=1110 and seg=40 (snapshot 0); the first frame_done SHALL occur 4*REFRESH_DIV+1 edges after release.

Verification (REFRESH_DIV=4, DP_POS=2)
REQ-027 Hold reset=0 -> an=1111, seg=7F, dp=1, frame_done=0; release -> an=1110, seg=40 next edge.
REQ-028 d3..d0=0,1,2,3, snap pulse, blank_lz=0 -> after next frame wrap each slot lasts 4 cycles: an=1110/seg=30, 1101/24, 1011/79 with dp=0, 0111/40.
REQ-029 Change d0 to 9 mid-frame without snap -> seg unchanged through frames; snap mid-frame -> 9 (seg=10) appears only after the following frame wrap.
REQ-030 d3..d0=0,0,0,5, blank_lz=1, snap -> an=1110/seg=12 in slot 0, an=1111/seg=7F in slots 1-3, dp=1; all-zero snapshot -> slot 0 shows seg=40.
REQ-031 d0=4'hC snapped -> slot 0 seg=7F with an=1110; snap coincident with frame wrap -> new value visible in the very next slot 0.
REQ-032 Assert reset mid-frame with pending=1 -> reset values immediately; after release no load occurs until a new snap.
